phase_sequencer: RTL

//   Parametrised top-level sequencer for the accelerator datapath. Steps through
//   N_PHASES execution phases (GET_PARAM, GET_DATA, EX, WRIT_PRE, WRITE_BACK by default).

---
 rtl/seq_pkg.sv | 21 ++
 rtl/phase_watchdog.sv | 42 ++++
 rtl/phase_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the phase sequencer: top-level state encoding and
// the default phase index names of the accelerator datapath.
package seq_pkg;

  localparam int SEQ_STATE_W = 2;

  typedef enum logic [SEQ_STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } seq_state_e;

  // Default phase order of one iteration.
  localparam int PH_GET_PARAM  = 0;
  localparam int PH_GET_DATA   = 1;
  localparam int PH_EX         = 2;
  localparam int PH_WRIT_PRE   = 3;
  localparam int PH_WRITE_BACK = 4;

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase ack watchdog: counts cycles spent waiting for an ack and flags
// expiry on the TIMEOUT-th consecutive waiting cycle of the same phase.
module phase_watchdog #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST_WAIT = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // Next count: clear on phase change / outside RUN, otherwise count waiting cycles.
  always_comb begin
    // NOTE: cnt_d is assigned before any branch so no path can leave it unassigned and infer a latch.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The current cycle is the TIMEOUT-th one without ack: the phase has run out of time.
  assign expired = en && (cnt_q == LAST_WAIT);

endmodule

// File: rtl/phase_sequencer.sv
// Top-level sequencer: walks N_PHASES phases per iteration, with optional
// ack-gated phases, iteration limit, graceful finish, abort and watchdog.
module phase_sequencer
  import seq_pkg::*;
#(
  parameter int                    N_PHASES = 5,
  parameter int                    PH_W     = 3,
  parameter logic [N_PHASES-1:0]   ACK_MASK = '0,
  parameter int                    ITER_W   = 16,
  parameter int                    TIMEOUT  = 0,
  parameter int                    TO_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ITER_W-1:0]      iter_limit,
  input  logic                   finish,
  input  logic                   abort,
  input  logic                   phase_ack,
  output logic [SEQ_STATE_W-1:0] state,
  output logic [PH_W-1:0]        phase,
  output logic [N_PHASES-1:0]    phase_onehot,
  output logic                   phase_start,
  output logic [ITER_W-1:0]      iter_count,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  seq_state_e        state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              phase_start_q, phase_start_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] limit_q, limit_d;
  logic              finish_pend_q, finish_pend_d;

  logic              is_ack_phase;
  logic              last_phase;
  logic              phase_done;
  logic [ITER_W-1:0] iter_inc;
  logic              stop_now;
  logic              wd_clr, wd_en, wd_expired;

  // Phase attributes: does the current phase wait for an ack, and is it the last one.
  always_comb begin
    is_ack_phase = 1'b0;
    for (int i = 0; i < N_PHASES; i++) begin
      if (phase_q == PH_W'(i)) is_ack_phase = ACK_MASK[i];
    end
  end

  assign last_phase = (phase_q == PH_W'(N_PHASES - 1));
  assign phase_done = (state_q == RUN) && (!is_ack_phase || phase_ack);

  // Saturating increment so an unbounded run never wraps the count.
  assign iter_inc = (&iter_q) ? iter_q : iter_q + ITER_W'(1);
  assign stop_now = ((limit_q != '0) && (iter_inc == limit_q)) || finish_pend_q || finish;

  // Watchdog only counts while an ack phase is actually waiting.
  assign wd_en  = (state_q == RUN) && is_ack_phase && !phase_ack;
  assign wd_clr = (state_q != RUN) || phase_done;

  generate
    if (TIMEOUT > 0) begin : g_wd
      phase_watchdog #(
        .TO_W   (TO_W),
        .TIMEOUT(TIMEOUT)
      ) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expired(wd_expired)
      );
    end else begin : g_no_wd
      logic unused_wd;
      assign unused_wd  = wd_clr ^ wd_en;
      assign wd_expired = 1'b0;
    end
  endgenerate

  // Next-state logic: abort, then watchdog, then phase completion, then finish latch.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    phase_start_d = 1'b0;
    iter_d        = iter_q;
    limit_d       = limit_q;
    finish_pend_d = finish_pend_q;

    if (abort) begin
      state_d       = IDLE;
      phase_d       = '0;
      iter_d        = '0;
      finish_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d       = RUN;
            phase_d       = '0;
            phase_start_d = 1'b1;
            iter_d        = '0;
            limit_d       = iter_limit;
            finish_pend_d = 1'b0;
          end
        end
        RUN: begin
          if (wd_expired) begin
            state_d       = ERR;
            phase_d       = '0;
            finish_pend_d = 1'b0;
          end else begin
            if (finish) finish_pend_d = 1'b1;
            if (phase_done) begin
              if (!last_phase) begin
                phase_d       = phase_q + PH_W'(1);
                phase_start_d = 1'b1;
              end else begin
                iter_d  = iter_inc;
                phase_d = '0;
                if (stop_now) begin
                  state_d       = DONE;
                  finish_pend_d = 1'b0;
                end else begin
                  phase_start_d = 1'b1;
                end
              end
            end
          end
        end
        default: begin
          // ERR is sticky; only abort or rst leave it.
        end
      endcase
    end
  end

  // State, phase, iteration and finish registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      phase_start_q <= 1'b0;
      iter_q        <= '0;
      limit_q       <= '0;
      finish_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      phase_start_q <= phase_start_d;
      iter_q        <= iter_d;
      limit_q       <= limit_d;
      finish_pend_q <= finish_pend_d;
    end
  end

  // One-hot phase view, decoded from registers only; all-zero outside RUN.
  always_comb begin
    phase_onehot = '0;
    for (int i = 0; i < N_PHASES; i++) begin
      phase_onehot[i] = (state_q == RUN) && (phase_q == PH_W'(i));
    end
  end

  assign state       = state_q;
  assign phase       = phase_q;
  assign phase_start = phase_start_q;
  assign iter_count  = iter_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign error       = (state_q == ERR);

endmodule
